// File: rtl/fpu_pkg.sv
// Shared FPU types: the float container, finv pipeline depth and the tag
// that rides alongside the finv pipeline.
package fpu_pkg;

    typedef logic [31:0] float_t;

    localparam int FINV_LAT = 2;

    localparam float_t FLOAT_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic       vld;
        logic [2:0] id;
    } finv_tag_t;

endpackage

// File: rtl/finv.sv
// Pipelined single-precision reciprocal: operand register, then a result
// register. Two edges from x to y/ovf/udf. Round-to-nearest-even; tiny
// results flush to signed zero with udf, zero/denormal inputs give inf with ovf.
module finv
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        ovf,
    output logic        udf
);

    float_t      x_d, x_q;
    float_t      y_d, y_q;
    logic        ovf_d, ovf_q;
    logic        udf_d, udf_q;

    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] frac;
    logic [48:0] num;
    logic [48:0] den;
    logic [24:0] quo;
    logic        rem_nz;
    logic        rnd;
    logic [24:0] sig_rnd;
    logic        sig_unused;

    always_comb begin
        x_d    = x;
        sgn    = x_q[31];
        expo   = x_q[30:23];
        frac   = x_q[22:0];
        // 2^48 / {1.frac} yields a 24-bit significand plus one round bit.
        num    = 49'h1_0000_0000_0000;
        den    = {25'b0, 1'b1, frac};
        quo    = 25'(num / den);
        rem_nz = (num % den) != 49'd0;
        rnd    = quo[0] & (rem_nz | quo[1]);
        sig_rnd = {1'b0, quo[24:1]} + {24'b0, rnd};
        sig_unused = sig_rnd[23];

        y_d   = '0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (expo == 8'hFF) begin
            y_d = (frac != 23'd0) ? FLOAT_QNAN : {sgn, 31'b0};
        end else if (expo == 8'h00) begin
            y_d   = {sgn, 8'hFF, 23'b0};
            ovf_d = 1'b1;
        end else if (frac == 23'd0) begin
            if (expo == 8'hFE) begin
                y_d   = {sgn, 31'b0};
                udf_d = 1'b1;
            end else begin
                y_d = {sgn, 8'hFE - expo, 23'b0};
            end
        end else if (expo >= 8'd253) begin
            y_d   = {sgn, 31'b0};
            udf_d = 1'b1;
        end else begin
            y_d = {sgn, 8'd253 - expo + {7'b0, sig_rnd[24]}, sig_rnd[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
    end

    assign y   = y_q;
    assign ovf = ovf_q;
    assign udf = udf_q;

endmodule

// File: rtl/finv_arbiter.sv
// Round-robin sharing of one pipelined finv among N_REQ requesters, with a
// tag pipe steering each result into a one-entry per-requester result buffer.
module finv_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int FINV_LAT = fpu_pkg::FINV_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     res_valid,
    output logic [N_REQ*32-1:0]  res_y,
    output logic [N_REQ-1:0]     res_ovf,
    output logic [N_REQ-1:0]     res_udf,
    input  logic [N_REQ-1:0]     res_ready,
    output logic                 busy
);

    localparam int IDW = $clog2(N_REQ);

    // Handshakes: an operand moves on a posedge where req_valid[i] && req_ready[i];
    // a result moves where res_valid[i] && res_ready[i]. Valid never waits on ready.
    logic [N_REQ-1:0]    outstanding_d, outstanding_q;
    logic [N_REQ-1:0]    res_valid_d, res_valid_q;
    logic [N_REQ-1:0]    res_ovf_d, res_ovf_q;
    logic [N_REQ-1:0]    res_udf_d, res_udf_q;
    logic [N_REQ*32-1:0] res_y_d, res_y_q;
    logic [IDW-1:0]      rr_d, rr_q;
    finv_tag_t           tag_d [FINV_LAT];
    finv_tag_t           tag_q [FINV_LAT];

    logic [N_REQ-1:0]    elig;
    logic [IDW:0]        pick;
    logic                grant;
    logic [IDW-1:0]      gidx;
    finv_tag_t           tag_out;
    float_t              finv_x;
    float_t              finv_y;
    logic                finv_ovf;
    logic                finv_udf;

    function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a,
                                               input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDW+1)'(N_REQ)) s = s - (IDW+1)'(N_REQ);
        return s[IDW-1:0];
    endfunction

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] elig_v,
                                             input logic [IDW-1:0]   ptr);
        logic [N_REQ-1:0] rot;
        logic             found;
        logic [IDW-1:0]   off;
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = elig_v[add_mod(ptr, IDW'(k))];
        end
        found = 1'b0;
        off   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = IDW'(j);
            end
        end
        return {found, add_mod(ptr, off)};
    endfunction

    always_comb begin
        elig  = req_valid & ~outstanding_q;
        pick  = rr_pick(elig, rr_q);
        grant = pick[IDW];
        gidx  = pick[IDW-1:0];

        req_ready     = '0;
        finv_x        = '0;
        rr_d          = rr_q;
        outstanding_d = outstanding_q;
        if (grant) begin
            req_ready[gidx]     = 1'b1;
            finv_x              = req_x[32*gidx +: 32];
            rr_d                = add_mod(gidx, IDW'(1));
            outstanding_d[gidx] = 1'b1;
        end

        tag_d[0] = '{vld: grant, id: 3'(gidx)};
        for (int s = 1; s < FINV_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        tag_out = tag_q[FINV_LAT-1];

        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_ovf_d   = res_ovf_q;
        res_udf_d   = res_udf_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (res_valid_q[k] && res_ready[k]) begin
                res_valid_d[k]   = 1'b0;
                outstanding_d[k] = 1'b0;
            end
            // Buffer k is empty here: outstanding[k] kept k from re-issuing.
            if (tag_out.vld && tag_out.id == 3'(k)) begin
                res_valid_d[k]        = 1'b1;
                res_y_d[32*k +: 32]   = finv_y;
                res_ovf_d[k]          = finv_ovf;
                res_udf_d[k]          = finv_udf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            res_valid_q   <= '0;
            res_y_q       <= '0;
            res_ovf_q     <= '0;
            res_udf_q     <= '0;
            rr_q          <= '0;
            for (int s = 0; s < FINV_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            res_valid_q   <= res_valid_d;
            res_y_q       <= res_y_d;
            res_ovf_q     <= res_ovf_d;
            res_udf_q     <= res_udf_d;
            rr_q          <= rr_d;
            for (int s = 0; s < FINV_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    finv u_finv (
        .clk (clk),
        .x   (finv_x),
        .y   (finv_y),
        .ovf (finv_ovf),
        .udf (finv_udf)
    );

    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_ovf   = res_ovf_q;
    assign res_udf   = res_udf_q;
    assign busy      = |outstanding_q;

endmodule

// File: tb/tb_finv_arbiter.sv
// Directed and soak bench for finv_arbiter: grant order, latency, back-pressure,
// flag routing, mid-flight reset and a reference-model soak.
module tb_finv_arbiter;

    localparam int N         = 4;
    localparam int SOAK_OPS  = 10000;
    localparam int SOAK_MAXC = 60000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   res_valid;
    logic [N*32-1:0] res_y;
    logic [N-1:0]   res_ovf;
    logic [N-1:0]   res_udf;
    logic [N-1:0]   res_ready;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] xs [N];
    logic [31:0] ys [N];
    logic [3:0]  pat_a [4];
    logic [3:0]  pat_b [4];
    logic [33:0] exp_q [N][$];
    logic        have_op [N];
    logic [31:0] op_x [N];

    finv_arbiter #(.N_REQ(N), .FINV_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_y     (res_y),
        .res_ovf   (res_ovf),
        .res_udf   (res_udf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        res_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        req_x[32*i +: 32] = v;
    endtask

    // Reference reciprocal for normal inputs, via double precision then
    // rounding to single (no double-rounding ties are reachable for 1/x).
    function automatic logic [33:0] ref_finv(input logic [31:0] x);
        logic [63:0] db;
        logic [63:0] yb;
        real         r;
        int          sexp;
        logic [24:0] m25;
        logic        rnd;
        db   = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        r    = 1.0 / $bitstoreal(db);
        yb   = $realtobits(r);
        sexp = int'(yb[62:52]) - 1023 + 127;
        if (sexp <= 0) return {2'b01, x[31], 31'b0};
        rnd = yb[28] & ((|yb[27:0]) | yb[29]);
        m25 = {2'b01, yb[51:29]} + {24'b0, rnd};
        if (m25[24]) begin
            sexp = sexp + 1;
            m25  = '0;
        end
        return {2'b00, x[31], 8'(sexp), m25[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), r[22:0]};
    endfunction

    initial begin
        int  cyc;
        int  n_gen;
        int  n_got;
        logic done;
        logic [33:0] e;

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        res_ready = '0;

        // ---- 1: single issue, latency, hold until consumed
        reset_dut();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_flags", {res_ovf, res_udf}, 0);
        chk("rst_busy", busy, 0);
        req_valid = 4'b0001;
        set_x(0, 32'h4000_0000);
        #1;
        chk("t1_ready_c0", req_ready, 4'b0001);
        @(negedge clk); #1;
        chk("t1_ready_c1", req_ready, 4'b0000);
        chk("t1_busy_c1", busy, 1);
        chk("t1_valid_c1", res_valid, 0);
        req_valid = '0;
        @(negedge clk); #1;
        chk("t1_valid_c2", res_valid, 0);
        @(negedge clk); #1;
        chk("t1_valid_c3", res_valid, 4'b0001);
        chk("t1_y_c3", res_y[31:0], 32'h3F00_0000);
        chk("t1_flags_c3", {res_ovf[0], res_udf[0]}, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("t1_hold_valid", res_valid, 4'b0001);
        chk("t1_hold_y", res_y[31:0], 32'h3F00_0000);
        res_ready = 4'b0001;
        @(negedge clk); #1;
        chk("t1_consumed", res_valid, 0);
        chk("t1_idle", busy, 0);

        // ---- 2: all requesters, full rate, rotating grants
        reset_dut();
        xs[0] = 32'h4000_0000; ys[0] = 32'h3F00_0000;
        xs[1] = 32'h4080_0000; ys[1] = 32'h3E80_0000;
        xs[2] = 32'h4100_0000; ys[2] = 32'h3E00_0000;
        xs[3] = 32'h4040_0000; ys[3] = 32'h3EAA_AAAB;
        for (int i = 0; i < N; i++) set_x(i, xs[i]);
        req_valid = 4'b1111;
        res_ready = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("t2_grant", req_ready, 4'b0001 << (c % 4));
            if (c >= 3) begin
                chk("t2_res_valid", res_valid, 4'b0001 << ((c - 3) % 4));
                chk("t2_res_y", res_y[32*((c-3)%4) +: 32], ys[(c-3)%4]);
            end else begin
                chk("t2_res_valid_early", res_valid, 0);
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        chk("t2_drained_busy", busy, 0);
        chk("t2_drained_valid", res_valid, 0);

        // ---- 3: requester 1 never consumes
        reset_dut();
        set_x(0, 32'hC000_0000);
        set_x(1, 32'h3F00_0000);
        set_x(2, 32'h3E00_0000);
        set_x(3, 32'h4200_0000);
        pat_a[0] = 4'b0001; pat_a[1] = 4'b0000; pat_a[2] = 4'b0100; pat_a[3] = 4'b1000;
        pat_b[0] = 4'b0010; pat_b[1] = 4'b0110; pat_b[2] = 4'b1010; pat_b[3] = 4'b0011;
        req_valid = 4'b1111;
        res_ready = 4'b1101;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c < 4) begin
                chk("t3_grant_first", req_ready, 4'b0001 << c);
                chk("t3_valid_first", res_valid, (c == 3) ? 4'b0001 : 4'b0000);
            end else begin
                chk("t3_grant", req_ready, pat_a[(c-4)%4]);
                chk("t3_valid", res_valid, pat_b[(c-4)%4]);
                chk("t3_y1_stable", res_y[63:32], 32'h4000_0000);
            end
            if (c == 7) chk("t3_y0", res_y[31:0], 32'hBF00_0000);
            if (c == 9) chk("t3_y2", res_y[95:64], 32'h4100_0000);
            if (c == 10) chk("t3_y3", res_y[127:96], 32'h3D00_0000);
        end

        // ---- 4: special operands and flag routing
        reset_dut();
        set_x(0, 32'h7F80_0001);
        set_x(1, 32'hFF80_0000);
        set_x(2, 32'h0000_0001);
        set_x(3, 32'h7F00_0000);
        req_valid = 4'b1111;
        repeat (4) @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("t4_valid", res_valid, 4'b1111);
        chk("t4_y_nan", res_y[31:0], 32'h7FC0_0000);
        chk("t4_y_inf", res_y[63:32], 32'h8000_0000);
        chk("t4_y_denorm", res_y[95:64], 32'h7F80_0000);
        chk("t4_y_big", res_y[127:96], 32'h0000_0000);
        chk("t4_ovf", res_ovf, 4'b0100);
        chk("t4_udf", res_udf, 4'b1000);

        // ---- 5: reset while three ops are in flight
        reset_dut();
        set_x(0, 32'h4000_0000);
        set_x(1, 32'h4080_0000);
        set_x(2, 32'h4100_0000);
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_req_ready", req_ready, 0);
        chk("t5_res_valid", res_valid, 0);
        chk("t5_res_y", res_y, 0);
        chk("t5_flags", {res_ovf, res_udf}, 0);
        chk("t5_busy", busy, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("t5_no_stale", {busy, res_valid}, 0);
        end

        // ---- 6: random soak against the reference model
        reset_dut();
        for (int i = 0; i < N; i++) begin
            have_op[i] = 1'b0;
            op_x[i]    = '0;
        end
        n_gen = 0;
        n_got = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < SOAK_MAXC) begin
            for (int i = 0; i < N; i++) begin
                if (!have_op[i] && n_gen < SOAK_OPS && $urandom_range(0, 3) != 0) begin
                    op_x[i]    = rand_float();
                    have_op[i] = 1'b1;
                    n_gen++;
                end
                req_valid[i] = have_op[i];
                set_x(i, op_x[i]);
                res_ready[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            chk("soak_onehot", $onehot0(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    chk("soak_expected", exp_q[i].size() > 0, 1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        chk("soak_result", {res_ovf[i], res_udf[i], res_y[32*i +: 32]}, e);
                        n_got++;
                    end
                end
                if (req_ready[i]) begin
                    chk("soak_single_outstanding", exp_q[i].size(), 0);
                    exp_q[i].push_back(ref_finv(op_x[i]));
                    have_op[i] = 1'b0;
                end
            end
            done = (n_gen == SOAK_OPS);
            for (int i = 0; i < N; i++) begin
                if (have_op[i] || exp_q[i].size() != 0) done = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("soak_finished_in_time", cyc < SOAK_MAXC, 1);
        chk("soak_delivered", n_got, SOAK_OPS);
        req_valid = '0;
        res_ready = '0;
        #1;
        chk("soak_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
